// File: rtl/uart_io.sv
// Byte-level 8N1 UART for the core's memory-mapped I/O port.
// The transmitter is fed by the tx_we strobe; received bytes land in a show-ahead RX FIFO.
module uart_io #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] tx_data,
    input  logic       tx_we,
    output logic       tx_busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_re,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned PTR_W        = $clog2(RX_DEPTH);
    localparam int unsigned FCNT_W       = PTR_W + 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_d, tx_busy_d;

    // Transmitter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx         <= tx_d;
            tx_busy    <= tx_busy_d;
        end
    end

    // Transmitter next state; tx/tx_busy are precomputed so they change with the state
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx;
        tx_busy_d  = tx_busy;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                if (tx_we) begin
                    tx_state_d = START;
                    tx_shift_d = tx_data;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            START: if (tx_cnt_q == BIT_LAST) begin
                tx_state_d = DATA;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = tx_shift_q[0];
            end
            DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_d     = tx_shift_q[1];
                end
            end
            STOP: if (tx_cnt_q == BIT_LAST) begin
                tx_state_d = IDLE;
                tx_cnt_d   = '0;
                tx_busy_d  = 1'b0;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    logic             rx_s1, rx_s2;
    state_t           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             frame_err_d, push_c;

    // Receiver synchroniser and state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_state_q   <= IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1        <= rx;
            rx_s2        <= rx_s1;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_frame_err <= frame_err_d;
        end
    end

    // Receiver next state: mid-bit sampling anchored on the start-bit midpoint
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + CNT_W'(1);
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2) begin
                    rx_state_d = START;
                    rx_bit_d   = '0;
                end
            end
            START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = rx_s2 ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2, rx_shift_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
            STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d    = '0;
                rx_state_d  = IDLE;
                push_c      = rx_s2;
                frame_err_d = !rx_s2;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    logic [7:0]        mem [RX_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [FCNT_W-1:0] fcount_q;
    logic              full_c, pop_c, wr_c;

    assign full_c   = (fcount_q == FIFO_FULL);
    assign rx_valid = (fcount_q != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr_q] : 8'h00;
    assign pop_c    = rx_re && rx_valid;
    assign wr_c     = push_c && (!full_c || pop_c);

    always_ff @(posedge clk) begin
        if (wr_c) mem[wr_ptr_q] <= rx_shift_q;
    end

    // FIFO pointers, occupancy and sticky overrun; a pop frees the slot for a same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fcount_q   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (wr_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (wr_c && !pop_c)      fcount_q <= fcount_q + FCNT_W'(1);
            else if (pop_c && !wr_c) fcount_q <= fcount_q - FCNT_W'(1);
            if (push_c && !wr_c) rx_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_io.sv
// Bench for uart_io at 16 clocks per bit and a 4-entry RX FIFO.
// A frame-level model predicts tx, tx_busy and the FIFO contents on every cycle.
module tb_uart_io;
    localparam int CPB    = 16;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 10 * CPB;
    localparam int RX_LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst, rx, tx, tx_we, tx_busy, rx_valid, rx_re, rx_overrun, rx_frame_err;
    logic [7:0] tx_data, rx_data;

    uart_io #(.CLK_FREQ(16), .BAUD(1), .RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .tx_data(tx_data), .tx_we(tx_we),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_re(rx_re),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         edge_n;
        logic [7:0] b;
        logic       good;
    } ev_t;

    ev_t        sched[$];
    logic [7:0] mq[$];
    bit         m_tx_active = 1'b0;
    int         m_tx_start = 0;
    logic [7:0] m_tx_byte = 8'h00;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    bit         rnd_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame starting now; the model learns when the stop bit will be judged.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        ev_t e;
        e.edge_n = cyc + RX_LAT;
        e.b      = b;
        e.good   = stop;
        sched.push_back(e);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    // Frame-level reference: transmit windows and a byte queue, advanced once per clock edge
    always @(posedge clk) begin : model
        bit  pop_ok;
        ev_t e;
        cyc = cyc + 1;
        if (rst) begin
            m_tx_active = 1'b0;
            mq.delete();
            sched.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            if (tx_we && (!m_tx_active || (cyc - m_tx_start) >= FRAME + 1)) begin
                m_tx_active = 1'b1;
                m_tx_start  = cyc;
                m_tx_byte   = tx_data;
            end
            pop_ok = rx_re && (mq.size() > 0);
            if (pop_ok) void'(mq.pop_front());
            m_ferr = 1'b0;
            if (sched.size() > 0 && sched[0].edge_n == cyc) begin
                e = sched.pop_front();
                if (!e.good)                 m_ferr = 1'b1;
                else if (mq.size() < DEPTH)  mq.push_back(e.b);
                else                         m_ovr = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [9:0] frame;
        logic       etx, ebusy;
        int         k;
        if (cyc >= 1) begin
            etx   = 1'b1;
            ebusy = 1'b0;
            if (m_tx_active && (cyc - m_tx_start) < FRAME) begin
                k     = cyc - m_tx_start;
                frame = {1'b1, m_tx_byte, 1'b0};
                etx   = frame[k / CPB];
                ebusy = 1'b1;
            end
            chk("tx", 32'(tx), 32'(etx));
            chk("tx_busy", 32'(tx_busy), 32'(ebusy));
            chk("rx_valid", 32'(rx_valid), 32'(mq.size() != 0));
            chk("rx_data", 32'(rx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
            chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
            chk("rx_frame_err", 32'(rx_frame_err), 32'(m_ferr));
        end
    end

    initial begin
        int          n;
        int          busy_n;
        int          ferr_n;
        int          a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [7:0]  ovr_exp[4]  = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0]  sim_exp[4]  = '{8'h11, 8'h12, 8'h13, 8'h14};

        rst = 1'b1; rx = 1'b1; tx_we = 1'b0; tx_data = 8'h00; rx_re = 1'b0;
        tick(3);
        rst = 1'b0;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_data", 32'(rx_data), 32'h00);
        tick(20);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_valid", 32'(rx_valid), 32'd0);

        // 0xA5 frame with an ignored write in the middle
        tx_data = 8'hA5; tx_we = 1'b1;
        tick();
        tx_we  = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 170; i++) begin
            if (tx_busy) busy_n++;
            if (i < FRAME && (i % CPB) == CPB / 2) chk("a5_bit", 32'(tx), 32'(a5_bits[i / CPB]));
            if (i == 80) begin
                tx_data = 8'h3C; tx_we = 1'b1;
            end else begin
                tx_we = 1'b0;
            end
            tick();
        end
        chk("tx_busy_cycles", 32'(busy_n), 32'd160);

        // Write issued in the first non-busy cycle is taken
        tx_data = 8'h81; tx_we = 1'b1;
        tick();
        tx_we = 1'b0;
        n = 0;
        while (tx_busy && n < 300) begin
            tick();
            n++;
        end
        chk("b2b_wait", 32'(tx_busy), 32'd0);
        tx_data = 8'h42; tx_we = 1'b1;
        tick();
        tx_we = 1'b0;
        chk("b2b_start_tx", 32'(tx), 32'd0);
        chk("b2b_start_busy", 32'(tx_busy), 32'd1);

        tick(20);
        chk("pre_rst_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_busy", 32'(tx_busy), 32'd0);

        // Receive latency and pop
        tick(5);
        n = 0;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                while (!rx_valid && n < 400) begin
                    tick();
                    n++;
                end
            end
        join
        chk("rx_latency", 32'(n), 32'd155);
        chk("rx_5a", 32'(rx_data), 32'h5A);
        rx_re = 1'b1;
        tick();
        rx_re = 1'b0;
        chk("rx_pop_empty", 32'(rx_valid), 32'd0);

        // Five bytes into four slots
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b1);
            tick(3);
        end
        tick(5);
        chk("overrun_set", 32'(rx_overrun), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("overrun_pop", 32'(rx_data), 32'(ovr_exp[i]));
            rx_re = 1'b1;
            tick();
            rx_re = 1'b0;
        end
        chk("overrun_drained", 32'(rx_valid), 32'd0);

        // Pop on the push edge of a full FIFO
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(2);
        for (int b = 0; b < 4; b++) begin
            send_frame(8'h10 + 8'(b), 1'b1);
            tick(3);
        end
        fork
            send_frame(8'h14, 1'b1);
            begin
                tick(RX_LAT - 1);
                rx_re = 1'b1;
                tick();
                rx_re = 1'b0;
            end
        join
        tick(3);
        chk("simul_no_overrun", 32'(rx_overrun), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("simul_pop", 32'(rx_data), 32'(sim_exp[i]));
            rx_re = 1'b1;
            tick();
            rx_re = 1'b0;
        end
        chk("simul_drained", 32'(rx_valid), 32'd0);

        // Short glitch is a false start
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(200);
        chk("glitch_no_push", 32'(rx_valid), 32'd0);

        // Bad stop bit
        ferr_n = 0;
        fork
            send_frame(8'h77, 1'b0);
            begin
                for (int i = 0; i < 220; i++) begin
                    if (rx_frame_err) ferr_n++;
                    tick();
                end
            end
        join
        chk("frame_err_pulses", 32'(ferr_n), 32'd1);
        chk("frame_err_no_push", 32'(rx_valid), 32'd0);

        // Randomised traffic on all three channels
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    send_frame(8'($urandom), ($urandom % 8) != 0);
                    tick(20 + int'($urandom % 10));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rx_re = ($urandom % 16) == 0;
                    tick();
                end
                rx_re = 1'b0;
            end
            begin
                while (!rnd_done) begin
                    if (($urandom % 64) == 0) begin
                        tx_data = 8'($urandom);
                        tx_we   = 1'b1;
                    end else begin
                        tx_we = 1'b0;
                    end
                    tick();
                end
                tx_we = 1'b0;
            end
        join
        tick(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_io.md
# uart_io

Byte-level UART peripheral sitting between the FPGA serial pins and the pipelined core's memory-mapped I/O port. It serialises bytes written by the core to address 0x1000_0000 and deserialises incoming 8N1 frames into a small show-ahead RX FIFO. The core reads that FIFO through the rx_data/rx_valid/rx_re handshake, and polls TX status at 0x1000_0004. The core's uart_tx_* / uart_rx_* ports connect one-to-one to this block.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115_200: serial bit rate.
- RX_DEPTH, 16: RX FIFO entries, power of two, ≥2.
- CLKS_PER_BIT: localparam, CLK_FREQ/BAUD with integer truncation (868 at defaults).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial input, asynchronous to clk, idle high.
- tx  out  1  serial output, idle high.
- tx_data  in  8  byte to transmit (core: uart_tx_data_out).
- tx_we  in  1  one-cycle transmit strobe (core: uart_tx_we_out).
- tx_busy  out  1  transmitter busy (core: uart_tx_busy_in).
- rx_data  out  8  FIFO head byte; 0 when the FIFO is empty.
- rx_valid  out  1  FIFO non-empty.
- rx_re  in  1  pop strobe (core: uart_rx_re_out); each high cycle pops one byte.
- rx_overrun  out  1  sticky; set when a received byte is dropped because the FIFO is full.
- rx_frame_err  out  1  one-cycle pulse when a frame's stop bit samples low.

## Operation
- Reset values: tx=1, tx_busy=0, rx_valid=0, rx_data=0, rx_overrun=0, rx_frame_err=0. Reset also clears both FSMs, the FIFO pointers and the count, and the synchroniser flops (to 1). A reset mid-frame aborts the frame and drives tx=1 on the next cycle.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Each state or bit lasts exactly CLKS_PER_BIT cycles.
  - tx_we is accepted only in IDLE; tx_data is latched on acceptance.
  - tx_we while busy is ignored; the byte is lost and the core is responsible for polling.
- RX synchroniser: two flops on rx. The FSM sees only the second flop.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a low level on the synchronised rx enters START and clears the bit counter.
  - START: waits CLKS_PER_BIT/2 cycles, then samples. If the sample is high it is a false start and the FSM returns to IDLE. If low, it enters DATA.
  - DATA: samples every CLKS_PER_BIT cycles, 8 samples, shifting LSB-first into the shift register.
  - STOP: samples after a further CLKS_PER_BIT cycles.
    - Sample high: push the byte.
    - Sample low: discard the byte and pulse rx_frame_err.
    - Either way, return to IDLE.
- FIFO, RX_DEPTH entries, show-ahead: rx_data is the head entry combinationally from the registered pointers, and rx_valid = (count≠0).
  - Push and pop in the same cycle on a non-empty FIFO: both happen and count is unchanged.
  - Push when full: if rx_re is also high in that cycle, both happen. Otherwise the byte is dropped and rx_overrun is set.
  - rx_re while empty is ignored, with no pointer change.
  - Pointers are log2(RX_DEPTH) bits and wrap modulo RX_DEPTH. Count is log2(RX_DEPTH)+1 bits.

## Timing
- tx_busy is registered. It is 1 from the cycle after tx_we is accepted through the last cycle of the stop bit, and 0 the following cycle.
  - An instruction polling 0x1000_0004 after the store therefore always sees busy=1.
- tx falls to 0 in the cycle after acceptance. The full frame lasts 10·CLKS_PER_BIT cycles.
- A back-to-back tx_we issued in the first cycle where tx_busy=0 is accepted; there is no idle gap beyond one cycle.
- RX push happens on the stop-bit sample edge. rx_valid and rx_data reflect the byte on the next cycle.
  - Input-to-valid latency: 2 synchroniser cycles + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles, measured from the rx falling edge.
- Pop: when rx_re is high at edge N, rx_data shows the next entry (or 0) after edge N. The core captures the pre-pop head at edge N.
- rx_frame_err is high for exactly the one cycle after the failing stop sample.

## Test plan
- Reset/idle: use CLK_FREQ=16, BAUD=1 (CLKS_PER_BIT=16). Hold rst for 3 cycles → tx=1, tx_busy=0, rx_valid=0, rx_data=0x00. These values persist with no stimulus.
- TX frame: tx_we with tx_data=0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles. tx_busy is high for 160 cycles. A second tx_we=0x3C issued mid-frame is not transmitted.
- RX loop: drive frame 0x5A on rx → rx_valid rises exactly 2+8+144+1 cycles after the falling edge, with rx_data=0x5A. A one-cycle rx_re then drops rx_valid.
- FIFO full/overrun (RX_DEPTH=4): send 0x01..0x05 without popping → rx_overrun=1. Pops return 0x01, 0x02, 0x03, 0x04, after which rx_valid=0.
- Simultaneous push/pop: with the FIFO full, assert rx_re on the push cycle → no overrun, count stays 4, and order is preserved.
- Errors: a 4-cycle low glitch on rx → no push. A frame 0x77 with a low stop bit → one rx_frame_err pulse, no push. Asserting rst mid-TX frame → tx=1 and tx_busy=0 on the next cycle.
